// File: rtl/alu_muldiv.sv
// ALU with single-cycle logic/arith ops and iterative multiply/divide
// writing the architectural HI/LO registers.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALU_Control,
    input  logic [WIDTH-1:0] Read_data1,
    input  logic [WIDTH-1:0] Read_data2,
    output logic [WIDTH-1:0] ALUresult,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_MTHI = 4'b0100;
    localparam logic [3:0] OP_MTLO = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MFHI = 4'b1101;
    localparam logic [3:0] OP_MFLO = 4'b1110;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t              state, next_state;
    logic [CNTW-1:0]     cnt;
    logic                md_div, neg_q, neg_r;
    logic [WIDTH-1:0]    a_reg, bmag_r, rem, quot;
    logic [2*WIDTH-1:0]  prod, mcand;

    logic                is_md, op_signed, op_div, a_neg, b_neg;
    logic [WIDTH-1:0]    amag, bmag, sc_res, fix_hi, fix_lo;
    logic [WIDTH:0]      shifted, diff;
    logic [2*WIDTH-1:0]  prod_s;

    assign is_md     = (ALU_Control[3:2] == 2'b10);
    assign op_signed = ~ALU_Control[0];
    assign op_div    = ALU_Control[1];
    assign busy      = (state != IDLE);

    // Operand magnitudes and sign bookkeeping for the iterative units
    always_comb begin
        a_neg = op_signed & Read_data1[WIDTH-1];
        b_neg = op_signed & Read_data2[WIDTH-1];
        amag  = a_neg ? -Read_data1 : Read_data1;
        bmag  = b_neg ? -Read_data2 : Read_data2;
    end

    // Single-cycle result selection
    always_comb begin
        sc_res = '0;
        case (ALU_Control)
            OP_AND:  sc_res = Read_data1 & Read_data2;
            OP_OR:   sc_res = Read_data1 | Read_data2;
            OP_ADD:  sc_res = Read_data1 + Read_data2;
            OP_SUB:  sc_res = Read_data1 - Read_data2;
            OP_SLT:  sc_res[0] = $signed(Read_data1) < $signed(Read_data2);
            OP_SLTU: sc_res[0] = Read_data1 < Read_data2;
            OP_NOR:  sc_res = ~(Read_data1 | Read_data2);
            OP_MFHI: sc_res = hi;
            OP_MFLO: sc_res = lo;
            OP_MTHI: sc_res = Read_data1;
            OP_MTLO: sc_res = Read_data1;
            default: sc_res = '0;
        endcase
    end

    // Restoring-division trial subtract for the current step
    always_comb begin
        shifted = {rem, quot[WIDTH-1]};
        diff    = shifted - {1'b0, bmag_r};
    end

    // Sign fix-up of the finished magnitude result; divide by zero is
    // special-cased so the signed path cannot disturb the all-ones quotient
    always_comb begin
        prod_s = neg_q ? -prod : prod;
        fix_hi = prod_s[2*WIDTH-1:WIDTH];
        fix_lo = prod_s[WIDTH-1:0];
        if (md_div) begin
            if (bmag_r == '0) begin
                fix_hi = a_reg;
                fix_lo = '1;
            end else begin
                fix_hi = neg_r ? -rem : rem;
                fix_lo = neg_q ? -quot : quot;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && is_md) next_state = RUN;
            RUN:     if (cnt == CNTW'(WIDTH - 1)) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: capture, iterate, and write back results
    always_ff @(posedge clk) begin
        if (reset) begin
            ALUresult <= '0;
            zero      <= 1'b1;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            md_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            a_reg     <= '0;
            bmag_r    <= '0;
            rem       <= '0;
            quot      <= '0;
            prod      <= '0;
            mcand     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_md) begin
                            cnt    <= '0;
                            md_div <= op_div;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            a_reg  <= Read_data1;
                            bmag_r <= bmag;
                            rem    <= '0;
                            prod   <= '0;
                            mcand  <= {{WIDTH{1'b0}}, amag};
                            // quot doubles as the multiplier shift register
                            quot   <= op_div ? amag : bmag;
                        end else begin
                            ALUresult <= sc_res;
                            zero      <= (sc_res == '0);
                            done      <= 1'b1;
                            if (ALU_Control == OP_MTHI) hi <= Read_data1;
                            if (ALU_Control == OP_MTLO) lo <= Read_data1;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + CNTW'(1);
                    if (md_div) begin
                        if (!diff[WIDTH]) begin
                            rem  <= diff[WIDTH-1:0];
                            quot <= {quot[WIDTH-2:0], 1'b1};
                        end else begin
                            rem  <= shifted[WIDTH-1:0];
                            quot <= {quot[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        if (quot[0]) prod <= prod + mcand;
                        mcand <= mcand << 1;
                        quot  <= quot >> 1;
                    end
                end
                FIX: begin
                    hi        <= fix_hi;
                    lo        <= fix_lo;
                    ALUresult <= fix_lo;
                    zero      <= (fix_lo == '0);
                    done      <= 1'b1;
                    cnt       <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
